// File: rtl/ifetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, issues single-beat memory
// requests and queues returned words (with PC+4) ahead of the IF/ID buffer.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] out_ins,
    output logic [31:0] out_pc4,
    output logic [31:0] out_jtarget,
    output logic        full,
    output logic        empty
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   pc_next;
    logic [31:0]   ins_q [DEPTH];
    logic [31:0]   pc4_q [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    // Request is withheld only at full, on redirect or in reset, so an
    // outstanding request and its address stay stable across wait states.
    assign imem_req  = !rst && !redirect && (count != FULL_COUNT);
    assign imem_addr = fetch_pc;
    assign pc_next   = fetch_pc + 32'd4;

    assign push = imem_req && imem_ready;
    assign pop  = out_valid && !stall;

    assign out_valid   = (count != '0) && !redirect;
    assign out_ins     = ins_q[rd_ptr];
    assign out_pc4     = pc4_q[rd_ptr];
    assign out_jtarget = {out_pc4[31:28], out_ins[25:0], 2'b00};
    assign full        = (count == FULL_COUNT);
    assign empty       = (count == '0);

    // Reset beats redirect, which beats any push/pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= pc_next;
                wr_ptr   <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ins_q[wr_ptr] <= imem_rdata;
            pc4_q[wr_ptr] <= pc_next;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed-vector bench for ifetch_queue: stimulus pushes expected entries to a
// scoreboard, a negedge monitor pops and compares each accepted output.
module tb_ifetch_queue;

    localparam logic [31:0] KEY = 32'hA5A50000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_ins;
    logic [31:0] out_pc4;
    logic [31:0] out_jtarget;
    logic        full;
    logic        empty;

    logic        use_fixed;
    logic [31:0] fixed_word;
    logic [63:0] sb[$];
    int          compared;
    int          mismatched;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h00000000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .stall(stall),
        .out_valid(out_valid), .out_ins(out_ins), .out_pc4(out_pc4),
        .out_jtarget(out_jtarget), .full(full), .empty(empty)
    );

    // Memory model: word = address ^ KEY unless a fixed word is forced.
    assign imem_rdata = use_fixed ? fixed_word : (imem_addr ^ KEY);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; expected request/address are hand-computed.
    task automatic applyStimulus(input logic ready, input logic stl, input logic redir,
                                 input logic [31:0] rpc, input logic exp_req,
                                 input logic [31:0] exp_addr);
        logic [31:0] exp_ins;
        @(posedge clk);
        #1;
        imem_ready  = ready;
        stall       = stl;
        redirect    = redir;
        redirect_pc = rpc;
        #2;
        checkOutput("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        checkOutput("imem_addr", imem_addr, exp_addr);
        if (redir) begin
            checkOutput("out_valid_redirect", {31'd0, out_valid}, 32'd0);
            sb.delete();
        end else if (exp_req && ready) begin
            exp_ins = use_fixed ? fixed_word : (exp_addr ^ KEY);
            sb.push_back({exp_ins, exp_addr + 32'd4});
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst        = 1'b1;
        imem_ready = 1'b0;
        redirect   = 1'b0;
        sb.delete();
        @(posedge clk);
        #3;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_empty", {31'd0, empty}, 32'd1);
        checkOutput("rst_imem_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_imem_addr", imem_addr, 32'h00000000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        checkOutput("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("post_rst_empty", {31'd0, empty}, 32'd1);
        checkOutput("post_rst_full", {31'd0, full}, 32'd0);
        checkOutput("post_rst_imem_req", {31'd0, imem_req}, 32'd1);
        checkOutput("post_rst_imem_addr", imem_addr, 32'h00000000);
    endtask

    // Monitor: every accepted output must match the oldest expected entry.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && out_valid === 1'b1 && stall === 1'b0) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_pop: got ins %h pc4 %h, expected no output", out_ins, out_pc4);
            end else begin
                e = sb.pop_front();
                checkOutput("out_ins", out_ins, e[63:32]);
                checkOutput("out_pc4", out_pc4, e[31:0]);
                checkOutput("out_jtarget", out_jtarget, {e[31:28], e[57:32], 2'b00});
            end
        end
    end

    initial begin
        compared    = 0;
        mismatched  = 0;
        rst         = 1'b1;
        imem_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        stall       = 1'b0;
        use_fixed   = 1'b0;
        fixed_word  = 32'd0;

        // Reset then stream
        doReset();
        applyStimulus(1, 0, 0, 0, 1, 32'h0);
        checkOutput("stream_first_valid", {31'd0, out_valid}, 32'd0);
        applyStimulus(1, 0, 0, 0, 1, 32'h4);
        checkOutput("stream_valid_rises", {31'd0, out_valid}, 32'd1);
        applyStimulus(1, 0, 0, 0, 1, 32'h8);
        applyStimulus(1, 0, 0, 0, 1, 32'hC);
        applyStimulus(0, 0, 0, 0, 1, 32'h10);
        applyStimulus(0, 0, 0, 0, 1, 32'h10);
        checkOutput("stream_drained", {31'd0, empty}, 32'd1);

        // Fill to full under stall, then drain in order
        doReset();
        applyStimulus(1, 1, 0, 0, 1, 32'h0);
        applyStimulus(1, 1, 0, 0, 1, 32'h4);
        applyStimulus(1, 1, 0, 0, 1, 32'h8);
        applyStimulus(1, 1, 0, 0, 1, 32'hC);
        applyStimulus(1, 1, 0, 0, 0, 32'h10);
        checkOutput("fill_full", {31'd0, full}, 32'd1);
        applyStimulus(1, 0, 0, 0, 0, 32'h10);
        applyStimulus(1, 0, 0, 0, 1, 32'h10);
        checkOutput("fill_not_full", {31'd0, full}, 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 32'h14);
        applyStimulus(0, 0, 0, 0, 1, 32'h14);
        applyStimulus(0, 0, 0, 0, 1, 32'h14);
        applyStimulus(0, 0, 0, 0, 1, 32'h14);
        checkOutput("fill_drained", {31'd0, out_valid}, 32'd0);

        // Memory wait states at address 8
        doReset();
        applyStimulus(1, 0, 0, 0, 1, 32'h0);
        applyStimulus(1, 0, 0, 0, 1, 32'h4);
        applyStimulus(0, 0, 0, 0, 1, 32'h8);
        applyStimulus(0, 0, 0, 0, 1, 32'h8);
        checkOutput("wait_empty", {31'd0, empty}, 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 32'h8);
        checkOutput("wait_no_valid", {31'd0, out_valid}, 32'd0);
        applyStimulus(1, 0, 0, 0, 1, 32'h8);
        applyStimulus(1, 0, 0, 0, 1, 32'hC);

        // Redirect with three entries queued and a concurrent response
        applyStimulus(1, 1, 0, 0, 1, 32'h10);
        applyStimulus(1, 1, 0, 0, 1, 32'h14);
        applyStimulus(1, 0, 1, 32'h00000103, 0, 32'h18);
        applyStimulus(0, 0, 0, 0, 1, 32'h100);
        checkOutput("redir_empty", {31'd0, empty}, 32'd1);
        checkOutput("redir_no_valid", {31'd0, out_valid}, 32'd0);
        applyStimulus(1, 0, 0, 0, 1, 32'h100);
        applyStimulus(0, 0, 0, 0, 1, 32'h104);

        // Address wrap and jump target
        applyStimulus(0, 0, 1, 32'hFFFFFFFC, 0, 32'h104);
        use_fixed  = 1'b1;
        fixed_word = 32'h08000010;
        applyStimulus(1, 0, 0, 0, 1, 32'hFFFFFFFC);
        applyStimulus(0, 1, 0, 0, 1, 32'h0);
        checkOutput("wrap_pc4", out_pc4, 32'h00000000);
        checkOutput("wrap_jtarget", out_jtarget, 32'h00000040);
        use_fixed = 1'b0;
        applyStimulus(1, 1, 0, 0, 1, 32'h0);

        // Reset mid-operation with two entries queued and stall held
        doReset();
        applyStimulus(0, 0, 0, 0, 1, 32'h0);
        checkOutput("mid_rst_no_stale", {31'd0, out_valid}, 32'd0);
        applyStimulus(1, 0, 0, 0, 1, 32'h0);
        applyStimulus(0, 0, 0, 0, 1, 32'h4);
        applyStimulus(0, 0, 0, 0, 1, 32'h4);
        checkOutput("final_empty", {31'd0, empty}, 32'd1);
        checkOutput("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Instruction fetch front-end with a prefetch FIFO that sits directly upstream of the IF/ID pipeline buffer. It owns the fetch PC and issues single-beat requests to instruction memory. Returned words are queued together with their PC+4 and jump target, and handed to the IF/ID buffer under a valid/stall handshake. A redirect from the branch/jump stage flushes the queue and restarts fetch at the new PC.

Parameters:
DEPTH, 4, queue entries; power of 2, >= 2
RESET_PC, 32'h00000000, fetch PC loaded on reset; bits [1:0] must be 0

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address, always equal to fetch_pc
imem_ready  input  1  memory accepts the request and returns data in the same cycle
imem_rdata  input  32  instruction word; valid when imem_req & imem_ready
redirect  input  1  flush and restart fetch (taken branch/jump)
redirect_pc  input  32  new fetch PC; bits [1:0] ignored and treated as 0
stall  input  1  downstream is not accepting this cycle
out_valid  output  1  head entry is valid
out_ins  output  32  head instruction
out_pc4  output  32  head entry address + 4
out_jtarget  output  32  {out_pc4[31:28], out_ins[25:0], 2'b00}
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- State: fetch_pc[31:0]; FIFO storage {ins, pc4} x DEPTH; rd_ptr and wr_ptr, each log2(DEPTH) bits; count, log2(DEPTH)+1 bits.
- Reset, when rst is high at the edge:
  - fetch_pc <= RESET_PC; pointers <= 0; count <= 0.
  - After reset: out_valid = 0, empty = 1, full = 0.
  - imem_req rises in the first cycle after reset is released.
  - rst overrides redirect and all handshakes. Mid-operation reset drops all queued entries.
- Request: imem_req = !rst & !redirect & (count < DEPTH). imem_addr = fetch_pc, combinational.
- Request stability:
  - While imem_req is high and imem_ready is low, imem_addr holds.
  - imem_req drops only on redirect or rst.
- Push, when imem_req & imem_ready:
  - Write {imem_rdata, fetch_pc+4} at wr_ptr; wr_ptr++; fetch_pc <= fetch_pc + 4.
  - Address arithmetic is modulo 2^32: 32'hFFFFFFFC + 4 wraps to 0, so out_pc4 for that entry is 0.
- Pop, when out_valid & !stall: rd_ptr++.
- Outputs:
  - out_valid = (count != 0) & !redirect.
  - out_ins, out_pc4 and out_jtarget come combinationally from the entry at rd_ptr.
  - When out_valid = 0 these outputs are don't-care.
- Push and pop in the same cycle: count is unchanged; both pointers advance.
- Full: count == DEPTH forces imem_req = 0, so no push occurs even if a pop happens that cycle. Fetch resumes the next cycle. Zero-bubble refill at full is not required.
- Empty: out_valid = 0 and no pop occurs. A push into an empty queue becomes visible on out_valid the next cycle (1-cycle latency from memory to output).
- Pointer wrap: pointers wrap modulo DEPTH; count never exceeds DEPTH.
- Redirect, with priority over push and pop, when redirect is high at the edge:
  - count <= 0; rd_ptr <= 0; wr_ptr <= 0.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - Any imem_ready in that cycle is ignored; imem_req is already 0.
  - out_valid is forced to 0 in the redirect cycle, so no pop occurs.
  - The first post-redirect request is issued the next cycle at redirect_pc.
- Back-to-back redirects: the last one wins.
- stall only gates pops; it does not stop fetch while count < DEPTH.

Test Plan:
- Reset then stream: hold rst 2 cycles; imem_ready = 1, stall = 0, memory returns addr^32'hA5A50000 -> imem_addr sequence 0, 4, 8, ...; out_valid first rises 1 cycle after the first push; out_pc4 sequence 4, 8, 12; out_ins matches the address of each entry.
- Fill and full: stall = 1, imem_ready = 1, DEPTH = 4 -> exactly 4 pushes (addr 0..12); full = 1; imem_req = 0 with imem_addr holding 16. Release stall -> 4 pops in order, and fetch resumes at 16.
- Memory wait states: imem_ready low for 3 cycles at addr 8 -> imem_req and imem_addr = 8 stay stable; no push occurs; the queue drains to empty and out_valid = 0 until the word arrives.
- Redirect mid-stream: 3 entries queued, redirect = 1 with redirect_pc = 32'h00000103 and imem_ready = 1 that cycle -> out_valid = 0 in the redirect cycle; the queue is empty next cycle; next imem_addr = 32'h00000100; the old entries and the concurrent response never appear.
- Wrap and jump target: redirect_pc = 32'hFFFFFFFC, imem_rdata = 32'h08000010 -> out_pc4 = 0, out_jtarget = 32'h00000040, next imem_addr = 0.
- Reset mid-operation: assert rst with 2 entries queued and stall = 1 -> the next cycle shows out_valid = 0, empty = 1, imem_addr = RESET_PC; no stale entry is popped after release.
